issue_buffer: RTL and testbench

//  Dual-port ring buffer between instruction fetch and the dual-issue decode stage.

---
 rtl/issue_buffer_pkg.sv | 16 +
 rtl/issue_buffer.sv | 113 +++++++++++
 tb/tb_issue_buffer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_buffer_pkg.sv
// Shared types for the fetch-to-decode issue buffer.
package issue_buffer_pkg;

    typedef logic [31:0] Word_t;
    typedef logic        Bit_t;

    // One fetched instruction as seen by decode.
    typedef struct packed {
        Word_t pc;
        Word_t inst;
        Bit_t  fetch_exc;
    } IssueEntry_t;

    localparam int ISSUE_BUF_DEPTH = 8;

endpackage

// File: rtl/issue_buffer.sv
// Dual-port ring buffer between instruction fetch and dual-issue decode.
// Fetch pushes one or two words per cycle; decode sees the two oldest
// entries as slots A/B and frees one or two per cycle. A redirect flush
// empties the buffer so no wrong-path instruction survives.
module issue_buffer
    import issue_buffer_pkg::*;
#(
    parameter  int DEPTH  = ISSUE_BUF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid0,
    input  logic              in_valid1,
    input  IssueEntry_t       in_entry0,
    input  IssueEntry_t       in_entry1,
    output logic              in_ready,
    output logic              out_valid_a,
    output logic              out_valid_b,
    output IssueEntry_t       out_entry_a,
    output IssueEntry_t       out_entry_b,
    input  logic              pop_a,
    input  logic              pop_b,
    output logic [ADDR_W:0]   occupancy
);

    localparam int OCC_W = ADDR_W + 1;

    IssueEntry_t       mem_q [DEPTH];
    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic              push_ok;
    logic [OCC_W-1:0]  n_push;
    logic [OCC_W-1:0]  n_pop;
    logic [ADDR_W-1:0] head_p1;
    logic [ADDR_W-1:0] tail_p1;

    assign head_p1 = head_q + ADDR_W'(1);
    assign tail_p1 = tail_q + ADDR_W'(1);

    // Two free slots are always reserved so a pair push can never overflow;
    // ready comes only from registered state, with no path from pop.
    assign in_ready    = (occ_q <= OCC_W'(DEPTH - 2));
    assign out_valid_a = (occ_q >= OCC_W'(1));
    assign out_valid_b = (occ_q >= OCC_W'(2));
    assign occupancy   = occ_q;

    assign out_entry_a = out_valid_a ? mem_q[head_q]  : '0;
    assign out_entry_b = out_valid_b ? mem_q[head_p1] : '0;

    // Push acceptance: word 1 only rides along with word 0.
    always_comb begin
        push_ok = in_ready & in_valid0 & ~flush;
        n_push  = '0;
        if (push_ok) begin
            n_push = in_valid1 ? OCC_W'(2) : OCC_W'(1);
        end
    end

    // Decode pairing outcome: slot B frees only alongside slot A, and a
    // pop of an empty slot counts for nothing.
    always_comb begin
        n_pop = '0;
        if (pop_a && out_valid_a) begin
            n_pop = (pop_b && out_valid_b) ? OCC_W'(2) : OCC_W'(1);
        end
    end

    // Next pointers and count; flush empties everything and wins over push/pop.
    always_comb begin
        head_d = head_q + ADDR_W'(n_pop);
        tail_d = tail_q + ADDR_W'(n_push);
        occ_d  = occ_q + n_push - n_pop;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end
    end

    // Pointer/count registers; reset outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Entry storage; validity lives in the count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[tail_q] <= in_entry0;
            if (in_valid1) begin
                mem_q[tail_p1] <= in_entry1;
            end
        end
    end

    // Decode must never pop a slot that does not hold an instruction.
    popAValid: assert property (@(posedge clk) disable iff (rst || flush)
                                !(pop_a && !out_valid_a));
    popBValid: assert property (@(posedge clk) disable iff (rst || flush)
                                !(pop_a && pop_b && !out_valid_b));

endmodule

// File: tb/tb_issue_buffer.sv
// Directed self-checking bench for issue_buffer.
module tb_issue_buffer;
    import issue_buffer_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid0;
    logic        in_valid1;
    IssueEntry_t in_entry0;
    IssueEntry_t in_entry1;
    logic        in_ready;
    logic        out_valid_a;
    logic        out_valid_b;
    IssueEntry_t out_entry_a;
    IssueEntry_t out_entry_b;
    logic        pop_a;
    logic        pop_b;
    logic [3:0]  occupancy;

    int checks = 0;
    int errors = 0;

    issue_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid0   (in_valid0),
        .in_valid1   (in_valid1),
        .in_entry0   (in_entry0),
        .in_entry1   (in_entry1),
        .in_ready    (in_ready),
        .out_valid_a (out_valid_a),
        .out_valid_b (out_valid_b),
        .out_entry_a (out_entry_a),
        .out_entry_b (out_entry_b),
        .pop_a       (pop_a),
        .pop_b       (pop_b),
        .occupancy   (occupancy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic IssueEntry_t mk(input logic [31:0] pc);
        IssueEntry_t e;
        e.pc        = pc;
        e.inst      = ~pc;
        e.fetch_exc = pc[3];
        return e;
    endfunction

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush     = 1'b0;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_entry0 = '0;
        in_entry1 = '0;
        pop_a     = 1'b0;
        pop_b     = 1'b0;
    endtask

    task automatic drivePush(input logic [31:0] pc0, input logic two);
        in_valid0 = 1'b1;
        in_valid1 = two;
        in_entry0 = mk(pc0);
        in_entry1 = mk(pc0 + 32'd4);
    endtask

    task automatic checkOcc(input string name, input logic [3:0] exp);
        checks++;
        if (occupancy !== exp) begin
            errors++;
            $display("[TB] FAIL %s: occupancy=%0d expected=%0d", name, occupancy, exp);
        end
    endtask

    task automatic checkPc(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: pc=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checkOcc("reset_occ", 4'd0);
        checkBit("reset_ready", in_ready, 1'b1);
        checkBit("reset_valid_a", out_valid_a, 1'b0);
        checkBit("reset_valid_b", out_valid_b, 1'b0);
        checks++;
        if (out_entry_a !== IssueEntry_t'(0)) begin
            errors++;
            $display("[TB] FAIL reset_entry_a: got=%h expected=0", out_entry_a);
        end
    endtask

    task automatic test_push_pair();
        drivePush(32'h1000, 1'b1);
        step();
        idle();
        checkPc("pair_a_pc", out_entry_a.pc, 32'h1000);
        checkPc("pair_b_pc", out_entry_b.pc, 32'h1004);
        checks++;
        if (out_entry_b !== mk(32'h1004)) begin
            errors++;
            $display("[TB] FAIL pair_b_entry: got=%h expected=%h", out_entry_b, mk(32'h1004));
        end
        checkOcc("pair_occ", 4'd2);
        // in_valid1 alone writes nothing
        in_valid1 = 1'b1;
        in_entry1 = mk(32'hDEAD0000);
        step();
        idle();
        checkOcc("valid1_only_occ", 4'd2);
        pop_a = 1'b1;
        pop_b = 1'b1;
        step();
        idle();
        checkOcc("pair_drain_occ", 4'd0);
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            drivePush(32'h100 + 32'(k * 8), 1'b1);
            step();
        end
        idle();
        checkOcc("fill_occ", 4'd8);
        checkBit("fill_ready", in_ready, 1'b0);
        drivePush(32'h900, 1'b1);
        step();
        idle();
        checkOcc("fill_drop_occ", 4'd8);
        checkPc("fill_drop_a", out_entry_a.pc, 32'h100);
        pop_a = 1'b1;
        step();
        idle();
        checkOcc("fill_popa_occ", 4'd7);
        checkBit("fill_popa_ready", in_ready, 1'b0);
        checkPc("fill_popa_a", out_entry_a.pc, 32'h104);
        pop_a = 1'b1;
        pop_b = 1'b1;
        step();
        idle();
        checkOcc("fill_popab_occ", 4'd5);
        checkBit("fill_popab_ready", in_ready, 1'b1);
        checkPc("fill_popab_a", out_entry_a.pc, 32'h10C);
        checkPc("fill_popab_b", out_entry_b.pc, 32'h110);
        // drain remaining five: pair, pair, single
        pop_a = 1'b1;
        pop_b = 1'b1;
        step();
        step();
        pop_b = 1'b0;
        step();
        idle();
        checkOcc("fill_drain_occ", 4'd0);
    endtask

    task automatic test_wrap();
        // head=tail=2 here; five push/pop rounds land both on 7
        for (int k = 0; k < 5; k++) begin
            drivePush(32'h500 + 32'(k * 4), 1'b0);
            step();
            idle();
            pop_a = 1'b1;
            step();
            idle();
        end
        checkOcc("wrap_empty_occ", 4'd0);
        drivePush(32'h2000, 1'b1);
        step();
        idle();
        checkPc("wrap_a", out_entry_a.pc, 32'h2000);
        checkPc("wrap_b", out_entry_b.pc, 32'h2004);
        checkOcc("wrap_occ", 4'd2);
        pop_a = 1'b1;
        pop_b = 1'b1;
        step();
        idle();
        checkOcc("wrap_pop_occ", 4'd0);
        checks++;
        if (dut.head_q !== 3'd1) begin
            errors++;
            $display("[TB] FAIL wrap_head: head=%0d expected=1", dut.head_q);
        end
    endtask

    task automatic test_back_to_back();
        drivePush(32'h4000, 1'b1);
        step();
        drivePush(32'h4008, 1'b0);
        step();
        idle();
        checkOcc("b2b_pre_occ", 4'd3);
        drivePush(32'h400C, 1'b1);
        pop_a = 1'b1;
        pop_b = 1'b1;
        step();
        idle();
        checkOcc("b2b_occ", 4'd3);
        checkPc("b2b_a", out_entry_a.pc, 32'h4008);
        checkPc("b2b_b", out_entry_b.pc, 32'h400C);
    endtask

    task automatic test_flush();
        drivePush(32'h4014, 1'b1);
        step();
        idle();
        checkOcc("flush_pre_occ", 4'd5);
        flush = 1'b1;
        drivePush(32'h7000, 1'b1);
        pop_a = 1'b1;
        pop_b = 1'b1;
        step();
        idle();
        checkOcc("flush_occ", 4'd0);
        checkBit("flush_valid_a", out_valid_a, 1'b0);
        checkBit("flush_ready", in_ready, 1'b1);
        drivePush(32'h3000, 1'b0);
        step();
        idle();
        checkPc("flush_push_a", out_entry_a.pc, 32'h3000);
        checkOcc("flush_push_occ", 4'd1);
        checkBit("flush_push_valid_b", out_valid_b, 1'b0);
        checkPc("flush_push_b_zero", out_entry_b.pc, 32'h0);
    endtask

    task automatic test_midstream_reset();
        rst = 1'b1;
        flush = 1'b1;
        step();
        rst = 1'b0;
        idle();
        checkOcc("rst_mid_occ", 4'd0);
        checkBit("rst_mid_valid_a", out_valid_a, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_push_pair();
        test_fill();
        test_wrap();
        test_back_to_back();
        test_flush();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
